// File: rtl/riscv_dram_arbiter.sv
// riscv_dram_arbiter
//   Two-port arbiter/sequencer in front of a single-port 128-bit block DRAM.
//   Port I serves I-cache line refills (read only). Port D serves D-cache
//   refills and writebacks (read/write). Grants are round-robin when both
//   ports request. Each access runs IDLE -> [WAIT] -> ACCESS -> RESP -> DONE.
//   The read line is captured from the DRAM at the end of RESP, and the
//   owner's done pulse is raised in DONE.
//
// Configuration macro: RISCV_DRAM_LATENCY_EN
//   Defined:   a WAIT state of MEM_LAT cycles follows each grant.
//              MEM_LAT = 0 skips WAIT.
//   Undefined: there is no WAIT state and no counter; MEM_LAT has no effect.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   i_req/i_addr             I-cache line read request; held until i_done
//   i_done/i_rdata           1-cycle completion pulse; registered read line
//   d_req/d_we/d_addr/d_wdata  D-cache request; held until d_done
//   d_done/d_rdata           1-cycle completion pulse; registered read line
//   busy                     high in every state except IDLE
//   mem_wren/mem_rden        DRAM strobes, decoded from state; never both high
//   mem_addr/mem_wdata       DRAM address and write data; hold the last latched values
//   mem_rdata                DRAM read data (1-cycle synchronous latency)

module riscv_dram_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 10,
  parameter int MEM_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [S_ADDR-1:0]     i_addr,
  output logic                  i_done,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [S_ADDR-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  busy,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [S_ADDR-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef RISCV_DRAM_LATENCY_EN
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RESP, DONE} state_t;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  logic [CNT_W-1:0] wait_cnt_reg;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;
  // MEM_LAT has no effect in this build.
  if (MEM_LAT < 0) begin : g_mem_lat_unused
  end
`endif

  state_t state_reg;
  logic   owner_reg;       // 1 = D port owns the current access
  logic   we_reg;          // latched write flag (always 0 for I)
  logic   last_grant_reg;  // 1 = D was granted last
  logic   grant_d;

  // When both ports request, grant the port that was not granted last.
  // When only one port requests, that port wins outright.
  always_comb begin
    grant_d = d_req && (!i_req || !last_grant_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      we_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      i_done         <= 1'b0;
      d_done         <= 1'b0;
      busy           <= 1'b0;
      mem_wren       <= 1'b0;
      mem_rden       <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      i_rdata        <= '0;
      d_rdata        <= '0;
`ifdef RISCV_DRAM_LATENCY_EN
      wait_cnt_reg   <= '0;
`endif
    end else begin
      // Strobes and done pulses last a single state and default low.
      mem_wren <= 1'b0;
      mem_rden <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (i_req || d_req) begin
            owner_reg      <= grant_d;
            last_grant_reg <= grant_d;
            we_reg         <= grant_d && d_we;
            mem_addr       <= grant_d ? d_addr : i_addr;
            if (grant_d) begin
              mem_wdata <= d_wdata;
            end
            busy <= 1'b1;
`ifdef RISCV_DRAM_LATENCY_EN
            if (MEM_LAT > 0) begin
              state_reg    <= WAIT;
              wait_cnt_reg <= CNT_W'(MEM_LAT - 1);
            end else begin
              state_reg <= ACCESS;
              mem_wren  <= grant_d && d_we;
              mem_rden  <= !(grant_d && d_we);
            end
`else
            state_reg <= ACCESS;
            mem_wren  <= grant_d && d_we;
            mem_rden  <= !(grant_d && d_we);
`endif
          end
        end

`ifdef RISCV_DRAM_LATENCY_EN
        WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg <= ACCESS;
            mem_wren  <= we_reg;
            mem_rden  <= !we_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
`endif

        ACCESS: begin
          state_reg <= RESP;
        end

        RESP: begin
          // The DRAM output is valid this cycle for a read issued in ACCESS.
          if (!we_reg) begin
            if (owner_reg) begin
              d_rdata <= mem_rdata;
            end else begin
              i_rdata <= mem_rdata;
            end
          end
          i_done    <= !owner_reg;
          d_done    <= owner_reg;
          state_reg <= DONE;
        end

        DONE: begin
          // No grant is taken here, so the requester can drop req at the next edge.
          state_reg <= IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
